// File: rtl/uart_rx_if.sv
// Serial line in, received byte and status pulses out, for the uart_rx receiver.
interface uart_rx_if;
  logic       uart_rxd;
  logic [7:0] dout;
  logic       valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  // Receiver side: listens to the line, drives the byte and status pulses.
  modport master (
    input  uart_rxd,
    output dout,
    output valid,
    output parity_err,
    output frame_err,
    output busy
  );

  // Consumer side: drives the line, observes the results.
  modport slave (
    output uart_rxd,
    input  dout,
    input  valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop. Samples mid-bit on a
// synchronized copy of the line and pulses valid/parity_err/frame_err for one cycle.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned PAR_MODE     = 0
) (
  input logic       clk,
  input logic       rst,
  uart_rx_if.master bus
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic            meta_q, meta_d;
  logic            rxd_s_q, rxd_s_d;
  logic            armed_q, armed_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_bit_q, par_bit_d;
  logic [7:0]      dout_q, dout_d;
  logic            valid_q, valid_d;
  logic            parity_err_q, parity_err_d;
  logic            frame_err_q, frame_err_d;
  logic            busy_q, busy_d;
  logic            tick;
  logic            par_exp;

  assign tick    = (cnt_q == CntMax);
  // Mode 0 demands a zero parity bit; mode 1 is even parity over the data.
  assign par_exp = (PAR_MODE == 1) ? ^shift_q : 1'b0;

  // Next-state: synchronizer shift, baud timing, bit capture and output pulses.
  always_comb begin
    state_d      = state_q;
    meta_d       = bus.uart_rxd;
    rxd_s_d      = meta_q;
    armed_d      = armed_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_bit_d    = par_bit_q;
    dout_d       = dout_q;
    valid_d      = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        // Armed only re-asserts once the line is seen high, so a held break
        // cannot start a new frame.
        if (rxd_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CntHalf) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (tick) begin
          cnt_d     = '0;
          shift_d   = {rxd_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StParity: begin
        if (tick) begin
          cnt_d     = '0;
          par_bit_d = rxd_s_q;
          state_d   = StStop;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (tick) begin
          // Leave at mid-stop so an immediately following start edge is caught.
          cnt_d   = '0;
          state_d = StIdle;
          if (rxd_s_q) begin
            dout_d       = shift_q;
            valid_d      = 1'b1;
            parity_err_d = (par_bit_q != par_exp);
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // All state and registered outputs; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      meta_q       <= 1'b1;
      rxd_s_q      <= 1'b1;
      armed_q      <= 1'b1;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_bit_q    <= 1'b0;
      dout_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      meta_q       <= meta_d;
      rxd_s_q      <= rxd_s_d;
      armed_q      <= armed_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_bit_q    <= par_bit_d;
      dout_q       <= dout_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: two receivers (parity modes 0 and 1) share one serial line.
// Frames come from a vector table plus hand-written corner sequences; expected
// results are queued when a frame is sent and popped when a receiver pulses.
module tb_uart_rx;

  localparam int CPB     = 16;
  localparam int CLK_P   = 10;
  localparam int LATENCY = 10 * CPB + CPB / 2 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  always #(CLK_P / 2) clk = ~clk;

  uart_rx_if bus0 ();
  uart_rx_if bus1 ();
  assign bus0.uart_rxd = rxd;
  assign bus1.uart_rxd = rxd;

  uart_rx #(.CLKS_PER_BIT(CPB), .PAR_MODE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx #(.CLKS_PER_BIT(CPB), .PAR_MODE(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic       ferr;
    logic       perr;
    logic [7:0] dout;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    int         gap;
    logic       exp_ferr;
    logic       exp_perr0;
    logic       exp_perr1;
  } vec_t;

  sb_t        q0[$];
  sb_t        q1[$];
  sb_t        e0;
  sb_t        e1;
  logic [7:0] model_dout = 8'h00;
  time        last_fall_t = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic send_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                            input logic exp_ferr, input logic perr0, input logic perr1);
    if (exp_ferr) begin
      q0.push_back('{ferr: 1'b1, perr: 1'b0, dout: model_dout});
      q1.push_back('{ferr: 1'b1, perr: 1'b0, dout: model_dout});
    end else begin
      model_dout = data;
      q0.push_back('{ferr: 1'b0, perr: perr0, dout: data});
      q1.push_back('{ferr: 1'b0, perr: perr1, dout: data});
    end
    last_fall_t = $time;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(par);
    send_bit(stop);
  endtask

  // Receiver 0 monitor: pops one expectation per pulse, also checks latency.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.valid || bus0.frame_err) begin
        if (q0.size() == 0) begin
          check("dut0_spurious_pulse", {bus0.valid, bus0.frame_err}, 2'b00);
        end else begin
          e0 = q0.pop_front();
          check("dut0_frame_err", bus0.frame_err, e0.ferr);
          check("dut0_valid", bus0.valid, !e0.ferr);
          check("dut0_dout", bus0.dout, e0.dout);
          check("dut0_parity_err", bus0.parity_err, e0.perr);
          if (bus0.valid) check("dut0_latency", int'(($time - last_fall_t) / CLK_P), LATENCY);
        end
      end else if (bus0.parity_err) begin
        check("dut0_parity_err_alone", bus0.parity_err, 1'b0);
      end
    end
  end

  // Receiver 1 monitor.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus1.valid || bus1.frame_err) begin
        if (q1.size() == 0) begin
          check("dut1_spurious_pulse", {bus1.valid, bus1.frame_err}, 2'b00);
        end else begin
          e1 = q1.pop_front();
          check("dut1_frame_err", bus1.frame_err, e1.ferr);
          check("dut1_valid", bus1.valid, !e1.ferr);
          check("dut1_dout", bus1.dout, e1.dout);
          check("dut1_parity_err", bus1.parity_err, e1.perr);
        end
      end else if (bus1.parity_err) begin
        check("dut1_parity_err_alone", bus1.parity_err, 1'b0);
      end
    end
  end

  initial begin
    #(500_000 * CLK_P);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  vec_t tbl[7];
  int   bcnt;
  logic busy_seen;

  initial begin
    //         data   par   stop  gap ferr  perr0 perr1
    tbl[0] = '{8'hA5, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h07, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{8'h01, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{8'h80, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'hFF, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{8'hC3, 1'b1, 1'b1, 2, 1'b0, 1'b1, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_dout", bus0.dout, 8'h00);
    check("rst_valid", bus0.valid, 1'b0);
    check("rst_parity_err", bus0.parity_err, 1'b0);
    check("rst_frame_err", bus0.frame_err, 1'b0);
    check("rst_busy", {bus0.busy, bus1.busy}, 2'b00);
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Table of frames; gap 0 makes the next frame follow back-to-back.
    foreach (tbl[i]) begin
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop, tbl[i].exp_ferr,
                 tbl[i].exp_perr0, tbl[i].exp_perr1);
      rxd = 1'b1;
      repeat (tbl[i].gap * CPB) @(negedge clk);
    end
    check("idle_busy_after_frames", {bus0.busy, bus1.busy}, 2'b00);
    check("idle_dout_hold", bus0.dout, model_dout);

    // Short glitch: START entered, rejected at mid-bit, no pulse.
    bcnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0) rxd = 1'b0;
      if (k == 4) rxd = 1'b1;
      if (bus0.busy) bcnt++;
      @(negedge clk);
    end
    check("glitch_busy_len_ok", (bcnt >= 1 && bcnt <= 8), 1'b1);
    check("glitch_busy_end", bus0.busy, 1'b0);

    // Stop bit low, then break: one frame_err, no retrigger while low.
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    busy_seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      busy_seen = busy_seen | bus0.busy | bus1.busy;
      @(negedge clk);
    end
    check("break_no_restart", busy_seen, 1'b0);
    check("break_dout_hold", bus0.dout, model_dout);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Reset during data bit 4 of an aborted 0x10 frame.
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    check("midframe_busy", bus0.busy, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_dout", {bus0.dout, bus1.dout}, 16'h0000);
    check("midrst_pulses", {bus0.valid, bus0.parity_err, bus0.frame_err}, 3'b000);
    check("midrst_busy", {bus0.busy, bus1.busy}, 2'b00);
    rst = 1'b0;
    model_dout = 8'h00;
    repeat (3 * CPB) @(negedge clk);
    check("postrst_idle", {bus0.busy, bus1.busy, bus0.valid}, 3'b000);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    rxd = 1'b1;
    repeat (3 * CPB) @(negedge clk);

    check("sb0_drained", q0.size(), 0);
    check("sb1_drained", q1.size(), 0);
    check("final_dout", bus0.dout, 8'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz -> 9,600 baud); SHALL be >= 8.
REQ-002 Parameter PAR_MODE, 0, parity-bit rule: 0 = parity bit SHALL be 0; 1 = even parity over the 8 data bits.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 uart_rxd  input  1  serial line, idle high, asynchronous to clk.
REQ-006 dout  output  8  last received data byte.
REQ-007 valid  output  1  one-cycle pulse: dout holds a new byte.
REQ-008 parity_err  output  1  one-cycle pulse coincident with valid when the parity rule fails.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 busy  output  1  high from start-edge detection until return to IDLE.

Function
REQ-011 Frame format SHALL be: start (0), 8 data bits LSB first, 1 parity bit, 1 stop (1); 11 bit times.
REQ-012 uart_rxd SHALL pass through a 2-flop synchronizer (rxd_s); all decisions use rxd_s only.
REQ-013 States SHALL be IDLE, START, DATA, PARITY, STOP; encoding is free.
REQ-014 IDLE: on rxd_s 1->0 while armed -> START, bit counter cleared, busy=1.
REQ-015 START: at count CLKS_PER_BIT/2-1 (mid start bit) sample rxd_s; 0 -> DATA with counter cleared; 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 DATA: sample rxd_s every CLKS_PER_BIT cycles from the mid-start point; shift LSB first; after the 8th sample -> PARITY.
REQ-017 PARITY: sample after one further CLKS_PER_BIT; store the parity bit -> STOP.
REQ-018 STOP: sample after one further CLKS_PER_BIT, then -> IDLE in the same transition (mid-stop return, so a following start edge is not missed).
REQ-019 Stop sample 1: dout <= shifted byte and valid=1 on the next clk; parity_err=1 in that same cycle if the REQ-002 rule fails.
REQ-020 Stop sample 0: frame_err=1 for one cycle; dout unchanged; valid and parity_err stay 0.
REQ-021 Armed flag: cleared on frame error; set when rxd_s is observed 1 in IDLE; a line held low (break) SHALL NOT retrigger START.
REQ-022 Baud counter width SHALL be clog2(CLKS_PER_BIT); it SHALL wrap to 0 at CLKS_PER_BIT-1 and never overflow.
REQ-023 Latency: valid SHALL rise exactly 1 clk after the stop-bit sample cycle, i.e. about 10.5 bit times + 3 clk after the line falling edge.
REQ-024 dout SHALL hold its value between valid pulses; no input handshake; each valid is a single pulse with no back-pressure.
REQ-025 busy SHALL be 0 in IDLE and 1 in all other states.

Reset
REQ-026 While rst=1: state=IDLE, synchronizer flops=1, armed=1, counters=0, shift register=0x00, dout=0x00, valid=0, parity_err=0, frame_err=0, busy=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse; after release, reception SHALL restart only on a new falling edge.

Verification (bench with CLKS_PER_BIT=16)
REQ-028 Frame 0xA5, parity 0, stop 1, PAR_MODE=0 -> dout=0xA5, valid high exactly 1 cycle, parity_err=0, frame_err=0, busy back to 0.
REQ-029 Low pulse of 4 clk on idle line -> no valid/frame_err, busy returns to 0 by clk 8 of START, state IDLE.
REQ-030 Frame 0x3C with stop bit 0, then line low 40 clk, then high -> one frame_err pulse, dout unchanged, no new START until the line is high.
REQ-031 Back-to-back frames 0x00 and 0xFF, no idle gap -> two valid pulses, dout=0x00 then 0xFF.
REQ-032 PAR_MODE=1, byte 0x07 with parity bit 0 (expected 1) -> valid=1 and parity_err=1 in the same cycle, dout=0x07.
REQ-033 rst pulse during data bit 4 -> all outputs at reset values, no valid; the next clean frame 0x5A is received correctly.
